mux_sweep_ctrl: RTL

Sequencer that drives the gate-select mux (inputs sw0, sw1, select[2:0]; output out) through every select code in a configured range and every {sw1,sw0} combination. It captures the mux output as a 4-bit truth table per select code, so the mux can be self-checked on the board without manual switch toggling. It sits between the board control logic (start/abort, result display) and the mux instance, replacing the switch inputs while a sweep runs.

---
 rtl/mux_sweep_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_sweep_ctrl.sv
// Sweep sequencer for the gate-select mux: walks select codes and {sw1,sw0}
// combinations, samples the mux output and assembles per-select truth tables.
module mux_sweep_ctrl #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned SEL_FIRST = 0,
  parameter int unsigned SEL_LAST  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        mux_out,
  output logic        sw0,
  output logic        sw1,
  output logic [2:0]  select,
  output logic        busy,
  output logic        done,
  output logic        tt_valid,
  output logic [2:0]  tt_sel,
  output logic [3:0]  tt_bits,
  output logic [31:0] result
);

  localparam int unsigned CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [2:0] SEL_LO    = 3'(SEL_FIRST);
  localparam logic [2:0] SEL_HI    = 3'(SEL_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_combo;
  logic [2:0]    r_shadow;

  logic          w_capture;
  logic          w_last_combo;
  logic          w_last_sel;
  logic [3:0]    w_table;

  assign w_capture    = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  assign w_last_combo = (r_combo == 2'd3);
  assign w_last_sel   = (select == SEL_HI);
  // Shadow shifts in from the top, so after three captures it holds bits 2..0.
  assign w_table      = {mux_out, r_shadow};

  // Mux switch inputs come straight from the combination register.
  assign sw0 = r_combo[0];
  assign sw1 = r_combo[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_combo  <= 2'd0;
      r_shadow <= 3'd0;
      select   <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt_valid <= 1'b0;
      tt_sel   <= 3'd0;
      tt_bits  <= 4'd0;
      result   <= 32'd0;
    end else begin
      done     <= 1'b0;
      tt_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_RUN;
            select  <= SEL_LO;
            r_combo <= 2'd0;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_combo <= 2'd0;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (!w_capture) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (!w_last_combo) begin
              r_shadow <= {mux_out, r_shadow[2:1]};
              r_combo  <= r_combo + 2'd1;
            end else begin
              tt_valid                     <= 1'b1;
              tt_sel                       <= select;
              tt_bits                      <= w_table;
              result[{select, 2'b00} +: 4] <= w_table;
              r_combo                      <= 2'd0;
              if (!w_last_sel) begin
                select <= select + 3'd1;
              end else begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
